muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port halt_sys  input  1  freezes all state while high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
REQ-007 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port result_lo  output  WIDTH  product low half / quotient.
REQ-012 SHALL have port result_hi  output  WIDTH  product high half / remainder.
REQ-013 SHALL have port div0  output  1  divide-by-zero flag.
REQ-014 SHALL have port overflow  output  1  signed-divide overflow flag.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-016 IDLE with start=1 SHALL latch op, a, b at the edge; next state CALC, or DONE if op is a divide and b==0.
REQ-017 CALC SHALL process one bit per cycle for exactly WIDTH cycles via a WIDTH-bit iteration counter, then go to FIX.
REQ-018 Multiply SHALL use shift-add on operand magnitudes; divide SHALL use restoring division on operand magnitudes.
REQ-019 FIX SHALL apply signs for signed ops and register results; next state DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Normal latency: done high in the (WIDTH+2)th cycle after the accepting edge (18 cycles at WIDTH=16).
REQ-022 Multiply: {result_hi,result_lo} SHALL be the full 2*WIDTH product; MULS two's-complement signed.
REQ-023 Divide: result_lo SHALL be the quotient truncated toward zero; result_hi the remainder, sign following the dividend.
REQ-024 Divide by zero SHALL skip CALC/FIX: done one cycle after acceptance; result_lo all ones, result_hi = a, div0=1.
REQ-025 DIVS with a = most-negative and b = -1 SHALL give result_lo = a, result_hi = 0, overflow=1.
REQ-026 div0 and overflow SHALL be valid with done and held until the next accepted start, which clears them.
REQ-027 result_lo/result_hi SHALL hold their values until the next FIX or div0 DONE overwrites them.
REQ-028 start while busy SHALL be ignored; no queueing.
REQ-029 start in the DONE cycle SHALL be ignored; acceptance earliest in the following IDLE cycle.
REQ-030 halt_sys=1 SHALL hold state, counter, datapath and outputs, with done held at its current value; start is not sampled.
REQ-031 halt_sys and rst low together: reset SHALL win.

Reset
REQ-032 rst low at a clock edge SHALL force IDLE, counter 0, busy=0, done=0, result_lo=0, result_hi=0, div0=0, overflow=0.
REQ-033 Reset mid-operation SHALL abandon the operation with no done pulse; a new start is accepted in the first cycle after rst goes high.

Verification
REQ-034 MULU a=0xFFFF b=0xFFFF -> done at cycle 18, hi=0xFFFE lo=0x0001, busy high cycles 1-18.
REQ-035 MULS a=0xFFFD(-3) b=0x0005 -> hi=0xFFFF lo=0xFFF1; DIVS a=0xFFF9(-7) b=0x0002 -> lo=0xFFFD hi=0xFFFF.
REQ-036 DIVU a=0x1234 b=0 -> done at cycle 1, lo=0xFFFF hi=0x1234 div0=1; next DIVU 100/7 -> lo=14 hi=2, div0 cleared.
REQ-037 DIVS a=0x8000 b=0xFFFF -> lo=0x8000 hi=0x0000 overflow=1.
REQ-038 Start MULU 3*4, then pulse start with other operands at cycle 5 and hold halt_sys cycles 8-10 -> second start ignored, done at cycle 21, lo=0x000C.
REQ-039 rst low at cycle 9 of a DIVU -> no done, all outputs 0 next cycle; a following MULU 2*2 -> lo=0x0004.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential multiplier/divider: one result bit per cycle over WIDTH cycles,
// shift-add multiply and restoring divide on operand magnitudes, signs applied at the end.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_sys,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div0,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int               LAST      = WIDTH - 1;
    localparam logic [WIDTH-1:0] LAST_ITER = LAST[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_r,    state_s;
    logic [WIDTH-1:0] cnt_r,      cnt_s;
    logic             is_div_r,   is_div_s;
    logic             neg_q_r,    neg_q_s;
    logic             neg_r_r,    neg_r_s;
    logic             ovf_pend_r, ovf_pend_s;
    logic [WIDTH-1:0] dvs_r,      dvs_s;
    logic [WIDTH-1:0] acc_hi_r,   acc_hi_s;
    logic [WIDTH-1:0] acc_lo_r,   acc_lo_s;
    logic             busy_r,     busy_s;
    logic             done_r,     done_s;
    logic [WIDTH-1:0] res_lo_r,   res_lo_s;
    logic [WIDTH-1:0] res_hi_r,   res_hi_s;
    logic             div0_r,     div0_s;
    logic             ovf_r,      ovf_s;

    logic             sgn_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand magnitudes and per-iteration datapath terms
    always_comb begin
        sgn_s     = op[0];
        neg_a_s   = sgn_s & a[WIDTH-1];
        neg_b_s   = sgn_s & b[WIDTH-1];
        mag_a_s   = neg_a_s ? neg_w(a) : a;
        mag_b_s   = neg_b_s ? neg_w(b) : b;
        sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, dvs_r} : {1'b0, ZERO_W});
        shifted_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        prod_s    = neg_q_r ? neg_2w({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
    end

    // Next-state, iteration and result update
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        is_div_s   = is_div_r;
        neg_q_s    = neg_q_r;
        neg_r_s    = neg_r_r;
        ovf_pend_s = ovf_pend_r;
        dvs_s      = dvs_r;
        acc_hi_s   = acc_hi_r;
        acc_lo_s   = acc_lo_r;
        res_lo_s   = res_lo_r;
        res_hi_s   = res_hi_r;
        div0_s     = div0_r;
        ovf_s      = ovf_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    cnt_s      = ZERO_W;
                    is_div_s   = op[1];
                    neg_q_s    = neg_a_s ^ neg_b_s;
                    neg_r_s    = neg_a_s;
                    ovf_pend_s = (op == 2'b11) && (a == MIN_NEG) && (b == ONES_W);
                    div0_s     = 1'b0;
                    ovf_s      = 1'b0;
                    acc_hi_s   = ZERO_W;
                    if (op[1] && (b == ZERO_W)) begin
                        // Divide by zero bypasses the datapath entirely
                        state_s  = S_DONE;
                        res_lo_s = ONES_W;
                        res_hi_s = a;
                        div0_s   = 1'b1;
                    end else if (op[1]) begin
                        state_s  = S_CALC;
                        dvs_s    = mag_b_s;
                        acc_lo_s = mag_a_s;
                    end else begin
                        state_s  = S_CALC;
                        dvs_s    = mag_a_s;
                        acc_lo_s = mag_b_s;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (is_div_r) begin
                    // Restoring step: remainder in acc_hi, quotient bits shift into acc_lo
                    if (shifted_s >= {1'b0, dvs_r}) begin
                        acc_hi_s = shifted_s[WIDTH-1:0] - dvs_r;
                        acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_s = shifted_s[WIDTH-1:0];
                        acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_s = sum_s[WIDTH:1];
                    acc_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
                end
                cnt_s = cnt_r + ONE_W;
                if (cnt_r == LAST_ITER) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX: begin
                if (is_div_r) begin
                    res_lo_s = neg_q_r ? neg_w(acc_lo_r) : acc_lo_r;
                    res_hi_s = neg_r_r ? neg_w(acc_hi_r) : acc_hi_r;
                    ovf_s    = ovf_pend_r;
                end else begin
                    res_lo_s = prod_s[WIDTH-1:0];
                    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
                end
                state_s = S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // State and output registers; halt_sys freezes everything, reset overrides halt
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= ZERO_W;
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            ovf_pend_r <= 1'b0;
            dvs_r      <= ZERO_W;
            acc_hi_r   <= ZERO_W;
            acc_lo_r   <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            res_lo_r   <= ZERO_W;
            res_hi_r   <= ZERO_W;
            div0_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (!halt_sys) begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            is_div_r   <= is_div_s;
            neg_q_r    <= neg_q_s;
            neg_r_r    <= neg_r_s;
            ovf_pend_r <= ovf_pend_s;
            dvs_r      <= dvs_s;
            acc_hi_r   <= acc_hi_s;
            acc_lo_r   <= acc_lo_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            res_lo_r   <= res_lo_s;
            res_hi_r   <= res_hi_s;
            div0_r     <= div0_s;
            ovf_r      <= ovf_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result_lo = res_lo_r;
    assign result_hi = res_hi_r;
    assign div0      = div0_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random operations with
// random halts and ignored starts, checked against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_sys = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, div0, overflow;
    logic [15:0] result_lo, result_hi;

    int n_cmp = 0;
    int n_mis = 0;

    muldiv_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .div0(div0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values
    function automatic void ref_model(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                                      output logic [15:0] lo, output logic [15:0] hi,
                                      output logic d0, output logic ov);
        longint ua, ub, sa, sb, p, q, r;
        ua = {48'd0, av};
        ub = {48'd0, bv};
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        d0 = 1'b0; ov = 1'b0; p = 0; q = 0; r = 0;
        case (o)
            2'b00: p = ua * ub;
            2'b01: p = sa * sb;
            2'b10: if (bv != 16'd0) begin q = ua / ub; r = ua % ub; end
            default: if (bv != 16'd0) begin q = sa / sb; r = sa % sb; end
        endcase
        if (!o[1]) begin
            lo = p[15:0];
            hi = p[31:16];
        end else if (bv == 16'd0) begin
            lo = 16'hFFFF; hi = av; d0 = 1'b1;
        end else if (o[0] && av == 16'h8000 && bv == 16'hFFFF) begin
            lo = 16'h8000; hi = 16'h0000; ov = 1'b1;
        end else begin
            lo = q[15:0]; hi = r[15:0];
        end
    endfunction

    // Called and returns just after a negedge. Halts during cycles hf..ht, extra start in cycle sat.
    task automatic do_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input int hf, input int ht, input int sat, input int exp_cyc, input bit rnd);
        logic [15:0] el, eh;
        logic ed, eo, hnow, seen, busy_ok;
        int cyc, nh, lat;
        ref_model(o, av, bv, el, eh, ed, eo);
        lat = ed ? 1 : 18;
        op = o; a = av; b = bv; start = 1'b1; halt_sys = 1'b0;
        cyc = 0; nh = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && cyc < 200) begin
            hnow = halt_sys;
            @(posedge clk);
            cyc++;
            if (hnow) nh++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
            if (cyc == sat || (rnd && $urandom_range(5) == 0)) begin
                start = 1'b1; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            halt_sys = seen ? 1'b0 : (rnd ? ($urandom_range(7) == 0) : (cyc >= hf && cyc <= ht));
        end
        start = 1'b0;
        check_eq("done_seen", longint'(seen), 1);
        check_eq("latency", cyc - nh, lat);
        if (exp_cyc > 0) check_eq("done_cycle", cyc, exp_cyc);
        check_eq("busy_during", longint'(busy_ok), 1);
        check_eq("busy_at_done", longint'(busy), 1);
        check_eq("result_lo", longint'(result_lo), longint'(el));
        check_eq("result_hi", longint'(result_hi), longint'(eh));
        check_eq("div0", longint'(div0), longint'(ed));
        check_eq("overflow", longint'(overflow), longint'(eo));
        if (rnd && $urandom_range(1) == 0) begin
            halt_sys = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("done_held", longint'(done), 1);
            halt_sys = 1'b0;
        end
        // A start during the DONE cycle must be ignored
        start = 1'b1; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse", longint'(done), 0);
        check_eq("idle_after", longint'(busy), 0);
        check_eq("lo_held", longint'(result_lo), longint'(el));
        check_eq("hi_held", longint'(result_hi), longint'(eh));
        check_eq("div0_held", longint'(div0), longint'(ed));
        check_eq("ovf_held", longint'(overflow), longint'(eo));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, longint'(busy), 0);
        check_eq({tag, "_done"}, longint'(done), 0);
        check_eq({tag, "_lo"}, longint'(result_lo), 0);
        check_eq({tag, "_hi"}, longint'(result_hi), 0);
        check_eq({tag, "_div0"}, longint'(div0), 0);
        check_eq({tag, "_ovf"}, longint'(overflow), 0);
    endtask

    initial begin
        logic [1:0] ro;
        logic [15:0] ra, rb;
        logic saw_done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        do_op(2'b00, 16'hFFFF, 16'hFFFF, 0, -1, -1, 18, 1'b0);
        do_op(2'b01, 16'hFFFD, 16'h0005, 0, -1, -1, 0, 1'b0);
        do_op(2'b11, 16'hFFF9, 16'h0002, 0, -1, -1, 0, 1'b0);
        do_op(2'b10, 16'h1234, 16'h0000, 0, -1, -1, 1, 1'b0);
        do_op(2'b10, 16'd100, 16'd7, 0, -1, -1, 18, 1'b0);
        do_op(2'b11, 16'h8000, 16'hFFFF, 0, -1, -1, 18, 1'b0);

        // Reset during cycle 9 of a divide abandons it without a done pulse
        op = 2'b10; a = 16'hBEEF; b = 16'h0013; start = 1'b1;
        saw_done = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_no_done", longint'(saw_done), 0);
        check_zero("midrst");
        rst = 1'b1;
        do_op(2'b00, 16'd2, 16'd2, 0, -1, -1, 18, 1'b0);

        do_op(2'b00, 16'd3, 16'd4, 8, 10, 5, 21, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(9) == 0) rb = 16'h0000;
            if ($urandom_range(9) == 0) begin ra = 16'h8000; rb = 16'hFFFF; end
            if ($urandom_range(9) == 0) rb = 16'($urandom_range(15));
            do_op(ro, ra, rb, 0, -1, -1, 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
